// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams, serializer port and grant status.
// The slave modport is the arbiter side, the master modport drives it.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]   i_req_valid;
  logic [8*NREQ-1:0] i_req_data;
  logic [NREQ-1:0]   i_req_last;
  logic [NREQ-1:0]   o_req_ready;
  logic [7:0]        o_tx_data;
  logic              o_tx_stb;
  logic              i_tx_busy;
  logic [IDW-1:0]    o_grant_id;
  logic              o_active;

  modport slave (
    input  i_req_valid,
    input  i_req_data,
    input  i_req_last,
    input  i_tx_busy,
    output o_req_ready,
    output o_tx_data,
    output o_tx_stb,
    output o_grant_id,
    output o_active
  );

  modport master (
    output i_req_valid,
    output i_req_data,
    output i_req_last,
    output i_tx_busy,
    input  o_req_ready,
    input  o_tx_data,
    input  o_tx_stb,
    input  o_grant_id,
    input  o_active
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin burst arbiter sharing one UART TX serializer.
// Define UART_TX_ARB_TAG_EN to prefix each burst with tag byte {5'b11110, grant}.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int IDW          = 3,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input logic              i_clk,
  input logic              i_reset_n,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
`ifdef UART_TX_ARB_TAG_EN
    S_GAP  = 2'd2,
    S_TAG  = 2'd3
`else
    S_GAP  = 2'd2
`endif
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IDW-1:0]  grant_q;
  logic [IDW-1:0]  grant_d;
  logic [IDW-1:0]  rr_q;
  logic [IDW-1:0]  rr_d;
  logic [7:0]      burst_q;
  logic [7:0]      burst_d;
  logic [7:0]      idle_q;
  logic [7:0]      idle_d;
  logic [7:0]      data_q;
  logic [7:0]      data_d;
  logic            stb_q;
  logic            stb_d;
  logic            last_q;
  logic            last_d;
  logic            act_q;
  logic            act_d;

  logic [NREQ-1:0] mask;
  logic            any_v;
  logic            hi_v;
  logic [IDW-1:0]  lo_idx;
  logic [IDW-1:0]  hi_idx;
  logic [IDW-1:0]  pick;

  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;
  logic            send_ok;
  logic [NREQ-1:0] ready;
  logic [7:0]      idle_inc;

  // Prefer the lowest valid index above rr_q, else wrap to the lowest valid.
  always_comb begin
    mask   = '0;
    lo_idx = '0;
    hi_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      mask[j] = IDW'(j) > rr_q;
    end
    any_v = |bus.i_req_valid;
    hi_v  = |(bus.i_req_valid & mask);
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (bus.i_req_valid[j]) begin
        lo_idx = IDW'(j);
      end
      if (bus.i_req_valid[j] && mask[j]) begin
        hi_idx = IDW'(j);
      end
    end
    pick = hi_v ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_q == IDW'(j)) begin
        sel_valid = bus.i_req_valid[j];
        sel_last  = bus.i_req_last[j];
        sel_data  = bus.i_req_data[8*j +: 8];
      end
    end
  end

  assign send_ok  = (state_q == S_SEND) && !bus.i_tx_busy && sel_valid;
  assign idle_inc = idle_q + 8'd1;

  always_comb begin
    ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      ready[j] = send_ok && (grant_q == IDW'(j));
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    data_d  = data_q;
    stb_d   = 1'b0;
    last_d  = last_q;
    act_d   = act_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_v) begin
          grant_d = pick;
          act_d   = 1'b1;
          burst_d = '0;
          idle_d  = '0;
          last_d  = 1'b0;
`ifdef UART_TX_ARB_TAG_EN
          state_d = S_TAG;
`else
          state_d = S_SEND;
`endif
        end
      end
`ifdef UART_TX_ARB_TAG_EN
      S_TAG: begin
        if (!bus.i_tx_busy) begin
          data_d  = {5'b11110, 3'(grant_q)};
          stb_d   = 1'b1;
          state_d = S_GAP;
        end
      end
`endif
      S_SEND: begin
        if (send_ok) begin
          data_d  = sel_data;
          stb_d   = 1'b1;
          burst_d = burst_q + 8'd1;
          last_d  = sel_last;
          idle_d  = '0;
          state_d = S_GAP;
        end else if (!bus.i_tx_busy) begin
          idle_d = idle_inc;
          if (idle_inc == 8'(IDLE_TIMEOUT)) begin
            rr_d    = grant_q;
            act_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (last_q || burst_q == 8'(MAX_BURST)) begin
          rr_d    = grant_q;
          act_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        act_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= IDW'(NREQ - 1);
      burst_q <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      stb_q   <= 1'b0;
      last_q  <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      stb_q   <= stb_d;
      last_q  <= last_d;
      act_q   <= act_d;
    end
  end

  assign bus.o_req_ready = ready;
  assign bus.o_tx_data   = data_q;
  assign bus.o_tx_stb    = stb_q;
  assign bus.o_grant_id  = grant_q;
  assign bus.o_active    = act_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with requester FIFOs and a serializer model.
// Expected byte streams are written out by hand per scenario.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 3;
  localparam int MAXB = 4;
  localparam int TMO  = 64;
  localparam int BLEN = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .IDW(IDW),
    .MAX_BURST(MAXB),
    .IDLE_TIMEOUT(TMO)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );

  logic [8:0]  mem [NREQ][64];
  logic [5:0]  head [NREQ];
  logic [5:0]  tail [NREQ];
  logic        force_busy = 1'b0;
  int          busy_cnt   = 0;
  logic [NREQ-1:0] acc    = '0;
  logic [31:0] cap [$];
  logic [31:0] exp_q [$];
  int vectors   = 0;
  int errors    = 0;
  int ready_bad = 0;
  int stb_cnt   = 0;
  int rdy_cnt   = 0;

  initial begin
    for (int n = 0; n < NREQ; n++) begin
      head[n] = '0;
      tail[n] = '0;
    end
  end

  always_comb begin
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    bus.i_req_last  = '0;
    for (int n = 0; n < NREQ; n++) begin
      bus.i_req_valid[n]      = head[n] != tail[n];
      bus.i_req_data[8*n +: 8] = mem[n][head[n]][7:0];
      bus.i_req_last[n]       = mem[n][head[n]][8];
    end
  end

  assign bus.i_tx_busy = force_busy | (busy_cnt != 0);

  always @(posedge clk) acc <= bus.o_req_ready & bus.i_req_valid;

  always @(negedge clk) begin
    for (int n = 0; n < NREQ; n++) begin
      if (acc[n]) head[n] <= head[n] + 6'd1;
    end
    if (bus.o_tx_stb) begin
      cap.push_back({21'b0, bus.o_grant_id, bus.o_tx_data});
      busy_cnt <= BLEN;
      stb_cnt  <= stb_cnt + 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (bus.o_req_ready != '0) begin
      rdy_cnt <= rdy_cnt + 1;
      if (bus.o_req_ready != (NREQ'(1) << bus.o_grant_id))
        ready_bad <= ready_bad + 1;
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(int n, logic [7:0] d, logic l);
    mem[n][tail[n]] = {l, d};
    tail[n] = tail[n] + 6'd1;
  endtask

  task automatic expect_b(int g, logic [7:0] d);
    exp_q.push_back({21'b0, 3'(g), d});
  endtask

  function automatic logic pending();
    logic p = 1'b0;
    for (int n = 0; n < NREQ; n++) begin
      if (head[n] != tail[n]) p = 1'b1;
    end
    return p;
  endfunction

  task automatic wait_idle(string tag);
    int n = 0;
    while ((pending() || bus.o_active) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (BLEN + 3) @(negedge clk);
    check({tag, "_done"}, 32'(n < 2000), 32'd1);
  endtask

  task automatic cmp_stream(string tag);
    int m;
    check({tag, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
    m = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_b%0d", tag, i), cap[i], exp_q[i]);
    end
    cap.delete();
    exp_q.delete();
  endtask

  initial begin
    int s0;
    int r0;
    int n;

    push(0, 8'h10, 1'b1);
    push(1, 8'h11, 1'b1);
    push(2, 8'h12, 1'b1);
    push(3, 8'h13, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_stb", 32'(bus.o_tx_stb), 32'd0);
    check("rst_data", 32'(bus.o_tx_data), 32'd0);
    check("rst_gid", 32'(bus.o_grant_id), 32'd0);
    check("rst_act", 32'(bus.o_active), 32'd0);
    check("rst_rdy", 32'(bus.o_req_ready), 32'd0);
    rst_n = 1'b1;
    expect_b(0, 8'h10);
    expect_b(1, 8'h11);
    expect_b(2, 8'h12);
    expect_b(3, 8'h13);
    wait_idle("rr");
    cmp_stream("rr");

    push(0, 8'h20, 1'b1);
    expect_b(0, 8'h20);
    wait_idle("wrap");
    cmp_stream("wrap");
    check("wrap_gid", 32'(bus.o_grant_id), 32'd0);

    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b0);
    push(1, 8'hA3, 1'b1);
    push(2, 8'hB1, 1'b1);
    expect_b(1, 8'hA1);
    expect_b(1, 8'hA2);
    expect_b(1, 8'hA3);
    expect_b(2, 8'hB1);
    wait_idle("burst");
    cmp_stream("burst");

    push(3, 8'h33, 1'b1);
    expect_b(3, 8'h33);
    wait_idle("pre");
    cmp_stream("pre");

    for (int i = 0; i < 10; i++) push(0, 8'(8'h40 + i), 1'b0);
    push(3, 8'h5A, 1'b1);
    for (int i = 0; i < 4; i++) expect_b(0, 8'(8'h40 + i));
    expect_b(3, 8'h5A);
    for (int i = 4; i < 10; i++) expect_b(0, 8'(8'h40 + i));
    wait_idle("maxb");
    cmp_stream("maxb");

    force_busy = 1'b1;
    push(1, 8'h55, 1'b1);
    s0 = stb_cnt;
    r0 = rdy_cnt;
    repeat (20) @(negedge clk);
    check("busy_stb", 32'(stb_cnt - s0), 32'd0);
    check("busy_rdy", 32'(rdy_cnt - r0), 32'd0);
    check("busy_act", 32'(bus.o_active), 32'd1);
    force_busy = 1'b0;
    expect_b(1, 8'h55);
    wait_idle("busy");
    cmp_stream("busy");

    push(2, 8'h66, 1'b0);
    n = 0;
    while (!bus.o_tx_stb && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_stb", 32'(n < 100), 32'd1);
    repeat (40) @(negedge clk);
    check("tmo_held", 32'(bus.o_active), 32'd1);
    repeat (40) @(negedge clk);
    check("tmo_rel", 32'(bus.o_active), 32'd0);
    check("tmo_gid", 32'(bus.o_grant_id), 32'd2);
    expect_b(2, 8'h66);
    cmp_stream("tmo");

    push(2, 8'h77, 1'b1);
    push(3, 8'h78, 1'b1);
    expect_b(3, 8'h78);
    expect_b(2, 8'h77);
    wait_idle("rot");
    cmp_stream("rot");

    push(2, 8'h41, 1'b1);
`ifdef UART_TX_ARB_TAG_EN
    expect_b(2, 8'hF2);
`endif
    expect_b(2, 8'h41);
    wait_idle("tag");
    cmp_stream("tag");

    check("ready_onehot", 32'(ready_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
